frame_sequencer: RTL and testbench

- Per-frame scheduler for the game datapath. A free-running tick divider defines game frames.
- Within each frame, issues in strict order: a flight-physics step request, an obstacle-scroll request, then a collision-check request. Each uses a req/done handshake.
- Owns the Initial/Play/Lose game state previously spread across obstacle_logic and flight_physics; replaces their free-running sys_clk advance.
- Sits between the board clock domain (Clk) and the physics, obstacle RAM and check logic. All of these run on Clk with enables.

---
 rtl/flappy_pkg.sv | 25 ++
 rtl/tick_divider.sv | 31 +++
 rtl/frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game datapath.
// - state_e          : frame sequencer state encoding (3-bit)
// - TICK_DIV_DEFAULT : Clk cycles per game frame (60 Hz at 100 MHz)
// - SCROLL_DIV_DEFAULT, SCORE_W
// - sat_inc()        : saturating increment for the score counter
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PHYS   = 3'd2,
    ST_SCROLL = 3'd3,
    ST_CHECK  = 3'd4,
    ST_LOSE   = 3'd5
  } state_e;

  localparam int TICK_DIV_DEFAULT   = 1666667;
  localparam int SCROLL_DIV_DEFAULT = 2;
  localparam int SCORE_W            = 8;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running enable generator: tick is high for one Clk cycle every
// TICK_DIV cycles (counter runs 0..TICK_DIV-1, tick at terminal count).
// Ports:
//   Clk     in  clock
//   reset_n in  asynchronous active-low reset (counter -> 0)
//   tick    out one-cycle enable pulse
module tick_divider #(
  parameter int TICK_DIV = 8
) (
  input  logic Clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: on every frame tick in Play, issues Phys_Req, then
// (every SCROLL_DIV frames) Scroll_Req, then Check_Req, each waiting for
// its Done pulse. Owns the Initial/Play/Lose game state and the frame and
// score counters.
// Ports:
//   Clk, reset_n                 clock, asynchronous active-low reset
//   Start, Ack                   leave Initial / leave Lose (1-cycle pulses)
//   Phys_Req/Phys_Done           physics step handshake
//   Scroll_Req/Scroll_Done       obstacle scroll handshake
//   Check_Req/Check_Done         collision check handshake
//   Lose, Score                  check results, valid with Check_Done
//   Q_Initial, Q_Play, Q_Lose    one-hot game state
//   Frame_Count, Score_Count     frames completed / points (saturating)
//   Overrun                      sticky: tick arrived mid-frame
// Optional build macro FRAME_SEQ_SPEEDUP_EN: the scroll divisor shrinks by
// one for every 8 points scored, never below 1.
module frame_sequencer
  import flappy_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int SCROLL_DIV = SCROLL_DIV_DEFAULT,
  parameter int FC_W       = 16
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               Start,
  input  logic               Ack,
  output logic               Phys_Req,
  input  logic               Phys_Done,
  output logic               Scroll_Req,
  input  logic               Scroll_Done,
  output logic               Check_Req,
  input  logic               Check_Done,
  input  logic               Lose,
  input  logic               Score,
  output logic               Q_Initial,
  output logic               Q_Play,
  output logic               Q_Lose,
  output logic [FC_W-1:0]    Frame_Count,
  output logic [SCORE_W-1:0] Score_Count,
  output logic               Overrun
);

  state_e               state_q, state_d;
  logic                 phys_req_q, phys_req_d;
  logic                 scroll_req_q, scroll_req_d;
  logic                 check_req_q, check_req_d;
  logic [FC_W-1:0]      frame_q, frame_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 overrun_q, overrun_d;
  logic [3:0]           scroll_cnt_q, scroll_cnt_d;
  logic                 tick;
  logic [3:0]           eff_div;
  logic                 scroll_due;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk     (Clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

`ifdef FRAME_SEQ_SPEEDUP_EN
  logic [4:0] speed_step;
  assign speed_step = score_q[SCORE_W-1:3];
  always_comb begin
    if (({1'b0, speed_step} + 6'd1) >= 6'(SCROLL_DIV)) eff_div = 4'd1;
    else                                               eff_div = 4'(SCROLL_DIV) - speed_step[3:0];
  end
`else
  assign eff_div = 4'(SCROLL_DIV);
`endif

  // ">=" rather than "==" so a divisor that shrinks below the current
  // count scrolls on the very next frame instead of wrapping the counter.
  assign scroll_due = (({1'b0, scroll_cnt_q} + 5'd1) >= {1'b0, eff_div});

  always_comb begin
    state_d      = state_q;
    phys_req_d   = 1'b0;
    scroll_req_d = 1'b0;
    check_req_d  = 1'b0;
    frame_d      = frame_q;
    score_d      = score_q;
    overrun_d    = overrun_q;
    scroll_cnt_d = scroll_cnt_q;

    case (state_q)
      ST_INIT: begin
        if (Start) begin
          state_d      = ST_IDLE;
          frame_d      = '0;
          score_d      = '0;
          overrun_d    = 1'b0;
          scroll_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (tick) begin
          state_d    = ST_PHYS;
          phys_req_d = 1'b1;
        end
      end
      ST_PHYS: begin
        if (tick) overrun_d = 1'b1;  // tick dropped, not queued
        if (Phys_Done) begin
          if (scroll_due) begin
            scroll_cnt_d = '0;
            state_d      = ST_SCROLL;
            scroll_req_d = 1'b1;
          end else begin
            scroll_cnt_d = scroll_cnt_q + 4'd1;
            state_d      = ST_CHECK;
            check_req_d  = 1'b1;
          end
        end
      end
      ST_SCROLL: begin
        if (tick) overrun_d = 1'b1;
        if (Scroll_Done) begin
          state_d     = ST_CHECK;
          check_req_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (tick) overrun_d = 1'b1;
        if (Check_Done) begin
          frame_d = frame_q + 1'b1;
          if (Score) score_d = sat_inc(score_q);
          state_d = Lose ? ST_LOSE : ST_IDLE;
        end
      end
      ST_LOSE: begin
        if (Ack) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      phys_req_q   <= 1'b0;
      scroll_req_q <= 1'b0;
      check_req_q  <= 1'b0;
      frame_q      <= '0;
      score_q      <= '0;
      overrun_q    <= 1'b0;
      scroll_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      phys_req_q   <= phys_req_d;
      scroll_req_q <= scroll_req_d;
      check_req_q  <= check_req_d;
      frame_q      <= frame_d;
      score_q      <= score_d;
      overrun_q    <= overrun_d;
      scroll_cnt_q <= scroll_cnt_d;
    end
  end

  assign Phys_Req    = phys_req_q;
  assign Scroll_Req  = scroll_req_q;
  assign Check_Req   = check_req_q;
  assign Q_Initial   = (state_q == ST_INIT);
  assign Q_Lose      = (state_q == ST_LOSE);
  assign Q_Play      = (state_q == ST_IDLE) || (state_q == ST_PHYS) ||
                       (state_q == ST_SCROLL) || (state_q == ST_CHECK);
  assign Frame_Count = frame_q;
  assign Score_Count = score_q;
  assign Overrun     = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  localparam int TD  = 8;
`ifdef FRAME_SEQ_SPEEDUP_EN
  localparam int SD  = 3;
`else
  localparam int SD  = 2;
`endif
  localparam int FCW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_i = 1'b0, ack_i = 1'b0;
  logic phys_done_i = 1'b0, scroll_done_i = 1'b0, check_done_i = 1'b0;
  logic lose_i = 1'b0, score_i = 1'b0;
  logic phys_req_o, scroll_req_o, check_req_o;
  logic q_initial_o, q_play_o, q_lose_o, overrun_o;
  logic [FCW-1:0] frame_count_o;
  logic [7:0]     score_count_o;

  always #5 clk = ~clk;

  frame_sequencer #(.TICK_DIV(TD), .SCROLL_DIV(SD), .FC_W(FCW)) dut (
    .Clk         (clk),
    .reset_n     (reset_n),
    .Start       (start_i),
    .Ack         (ack_i),
    .Phys_Req    (phys_req_o),
    .Phys_Done   (phys_done_i),
    .Scroll_Req  (scroll_req_o),
    .Scroll_Done (scroll_done_i),
    .Check_Req   (check_req_o),
    .Check_Done  (check_done_i),
    .Lose        (lose_i),
    .Score       (score_i),
    .Q_Initial   (q_initial_o),
    .Q_Play      (q_play_o),
    .Q_Lose      (q_lose_o),
    .Frame_Count (frame_count_o),
    .Score_Count (score_count_o),
    .Overrun     (overrun_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  // game: 0 Initial, 1 Play, 2 Lose. wait_kind / req: 0 none, 1 phys,
  // 2 scroll, 3 check. since_scroll = frames finished PHYS since last scroll.
  int cyc, m_game, m_wait, m_req, m_frames, m_score, m_since;
  bit m_busy, m_ovr;

  task automatic model_reset();
    cyc = 0; m_game = 0; m_wait = 0; m_req = 0;
    m_frames = 0; m_score = 0; m_since = 0; m_busy = 0; m_ovr = 0;
  endtask

  function automatic int eff_div();
    int d;
`ifdef FRAME_SEQ_SPEEDUP_EN
    d = SD - (m_score / 8);
    if (d < 1) d = 1;
`else
    d = SD;
`endif
    return d;
  endfunction

  task automatic model_advance(input bit s, input bit a, input bit pd, input bit sdn,
                               input bit cdn, input bit lo, input bit sc);
    bit tick;
    int nreq;
    tick = ((cyc % TD) == TD - 1);
    nreq = 0;
    if (m_game == 0) begin
      if (s) begin
        m_game = 1; m_busy = 0; m_wait = 0; m_frames = 0; m_score = 0; m_ovr = 0; m_since = 0;
      end
    end else if (m_game == 2) begin
      if (a) m_game = 0;
    end else if (!m_busy) begin
      if (tick) begin m_busy = 1; m_wait = 1; nreq = 1; end
    end else begin
      if (tick) m_ovr = 1;
      if (m_wait == 1 && pd) begin
        if (m_since + 1 >= eff_div()) begin m_since = 0; m_wait = 2; end
        else begin m_since++; m_wait = 3; end
        nreq = m_wait;
      end else if (m_wait == 2 && sdn) begin
        m_wait = 3; nreq = 3;
      end else if (m_wait == 3 && cdn) begin
        m_frames++;
        if (sc && m_score < 255) m_score++;
        m_busy = 0; m_wait = 0;
        if (lo) m_game = 2;
      end
    end
    m_req = nreq;
    cyc++;
  endtask

  // ---------------- stimulus knobs and responder ----------------
  int lat_lo[4], lat_hi[4];
  int p_score = 0, p_lose = 0, p_spur = 0;
  bit auto_start = 0, auto_ack = 0, force_start = 0, force_ack = 0;
  int pend = 0, cd = 0, n_phys = 0;

  task automatic set_lat(input int k, input int lo, input int hi);
    lat_lo[k] = lo; lat_hi[k] = hi;
  endtask

  // Called at a negedge: compare the current cycle, drive inputs for the
  // coming posedge, advance the model, move to the next negedge.
  task automatic step();
    logic [6:0] got_st, exp_st;
    bit s, a, pd, sdn, cdn, lo, sc;
    int kind;
    got_st = {q_initial_o, q_play_o, q_lose_o, phys_req_o, scroll_req_o, check_req_o, overrun_o};
    exp_st = {m_game == 0, m_game == 1, m_game == 2, m_req == 1, m_req == 2, m_req == 3, m_ovr};
    check_eq("status", 32'(got_st), 32'(exp_st));
    check_eq("frame_count", 32'(frame_count_o), 32'(m_frames % 65536));
    check_eq("score_count", 32'(score_count_o), 32'(m_score));
    if (phys_req_o) n_phys++;

    pd = 0; sdn = 0; cdn = 0;
    if (pend != 0) begin
      cd--;
      if (cd <= 0) begin
        case (pend)
          1: pd = 1;
          2: sdn = 1;
          default: cdn = 1;
        endcase
        pend = 0;
      end
    end
    kind = phys_req_o ? 1 : scroll_req_o ? 2 : check_req_o ? 3 : 0;
    if (kind != 0) begin
      pend = kind;
      cd = $urandom_range(lat_hi[kind], lat_lo[kind]);
    end

    s = 0; a = 0;
    if (force_start) begin s = 1; force_start = 0; end
    else if (auto_start && m_game == 0 && $urandom_range(3) == 0) s = 1;
    if (force_ack) begin a = 1; force_ack = 0; end
    else if (auto_ack && m_game == 2 && $urandom_range(3) == 0) a = 1;
    if (p_spur > 0) begin
      if (m_game != 0 && $urandom_range(99) < p_spur) s = 1;
      if (m_game != 2 && $urandom_range(99) < p_spur) a = 1;
      if ($urandom_range(99) < p_spur) begin
        case ($urandom_range(2))
          0: pd = 1;
          1: sdn = 1;
          default: cdn = 1;
        endcase
      end
    end
    lo = $urandom_range(1);
    sc = $urandom_range(1);
    if (cdn) begin
      lo = ($urandom_range(99) < p_lose);
      sc = ($urandom_range(99) < p_score);
    end

    start_i = s; ack_i = a; phys_done_i = pd; scroll_done_i = sdn;
    check_done_i = cdn; lose_i = lo; score_i = sc;
    model_advance(s, a, pd, sdn, cdn, lo, sc);
    @(negedge clk);
  endtask

  task automatic run_until_frames(input int target, input int budget);
    int k = 0;
    while (m_frames < target && k < budget) begin step(); k++; end
    check_eq("frames_reached", 32'(frame_count_o), 32'(target));
  endtask

  task automatic run_until_lose(input int budget);
    int k = 0;
    while (m_game != 2 && k < budget) begin step(); k++; end
    check_eq("lose_reached", 32'(q_lose_o), 32'd1);
  endtask

  task automatic run_until_scroll(input int budget);
    int k = 0;
    while (m_wait != 2 && k < budget) begin step(); k++; end
    check_eq("scroll_reached", 32'(scroll_req_o), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq(tag, {17'd0, q_initial_o, q_play_o, q_lose_o, phys_req_o, scroll_req_o,
                   check_req_o, overrun_o, score_count_o},
             {17'd0, 7'b1000000, 8'd0});
    check_eq({tag, "_fc"}, 32'(frame_count_o), 32'd0);
  endtask

  task automatic clear_inputs();
    start_i = 0; ack_i = 0; phys_done_i = 0; scroll_done_i = 0;
    check_done_i = 0; lose_i = 0; score_i = 0;
  endtask

  initial begin
    int n0;
    for (int k = 0; k < 4; k++) set_lat(k, 1, 1);
    model_reset();
    @(negedge clk);
    check_reset_vals("reset_vals");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Idle in Initial with spurious Ack and Done pulses.
    p_spur = 30;
    repeat (20) step();
    p_spur = 0;

    // Four frames, single-cycle responders, no points.
    force_start = 1;
    run_until_frames(4, 200);
    check_eq("fc_after_4", 32'(frame_count_o), 32'd4);

    // Three scored frames, then Lose and Score together.
    p_score = 100;
    run_until_frames(7, 200);
    p_lose = 100;
    run_until_lose(200);
    check_eq("score_at_lose", 32'(score_count_o), 32'd4);
    p_score = 0; p_lose = 0;
    repeat (20) step();
    force_ack = 1;
    step(); step();
    check_eq("ack_to_init", 32'(q_initial_o), 32'd1);
    force_start = 1;
    step(); step();
    check_eq("score_cleared", 32'(score_count_o), 32'd0);

    // Slow physics responder: overrun, single Phys_Req for the frame.
    set_lat(1, 20, 20);
    n0 = n_phys;
    run_until_frames(1, 200);
    check_eq("overrun_set", 32'(overrun_o), 32'd1);
    check_eq("single_phys_req", 32'(n_phys - n0), 32'd1);
    set_lat(1, 1, 1);
    run_until_frames(3, 100);

    // Randomized games with noise on every input.
    set_lat(1, 1, 12); set_lat(2, 1, 4); set_lat(3, 1, 4);
    p_score = 40; p_lose = 4; p_spur = 8; auto_start = 1; auto_ack = 1;
    repeat (4000) step();

    // Asynchronous reset in the middle of a scroll step.
    p_spur = 0; p_lose = 0; p_score = 0;
    set_lat(1, 1, 1); set_lat(2, 6, 6); set_lat(3, 1, 1);
    run_until_scroll(800);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    pend = 0;
    auto_start = 0; auto_ack = 0;
    set_lat(2, 1, 1);
    repeat (25) step();
    force_start = 1;
    run_until_frames(2, 100);

    // Long scoring run: exercises the scroll cadence as points accumulate.
    p_score = 100;
    run_until_frames(m_frames + 36, 600);
    check_eq("long_run_score", 32'(score_count_o), 32'(m_score));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
